// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, mnemonics and constants shared by the MIPS core decoder and the program loader
package mips_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_SUBI = 6'b000011;
  localparam logic [5:0] OP_ANDI = 6'b000100;
  localparam logic [5:0] OP_ORI  = 6'b000101;
  localparam logic [5:0] OP_SLTI = 6'b000111;
  localparam logic [5:0] OP_LW   = 6'b001000;
  localparam logic [5:0] OP_SW   = 6'b010000;
  localparam logic [5:0] OP_LB   = 6'b001001;
  localparam logic [5:0] OP_SB   = 6'b010001;
  localparam logic [5:0] OP_BEQ  = 6'b100011;
  localparam logic [5:0] OP_BNE  = 6'b100111;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JAL  = 6'b111001;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef enum logic [3:0] {
    M_R, M_ADDI, M_SUBI, M_ANDI, M_ORI, M_SLTI, M_LW, M_SW,
    M_LB, M_SB, M_BEQ, M_BNE, M_J, M_JAL, M_MOVE, M_ILLEGAL
  } mnem_t;
  function automatic logic [5:0] opcode(input mnem_t m);
    case (m)
      M_ADDI: return OP_ADDI;
      M_SUBI: return OP_SUBI;
      M_ANDI: return OP_ANDI;
      M_ORI:  return OP_ORI;
      M_SLTI: return OP_SLTI;
      M_LW:   return OP_LW;
      M_SW:   return OP_SW;
      M_LB:   return OP_LB;
      M_SB:   return OP_SB;
      M_BEQ:  return OP_BEQ;
      M_BNE:  return OP_BNE;
      M_J:    return OP_J;
      M_JAL:  return OP_JAL;
      M_MOVE: return OP_MOVE;
      default: return OP_R;
    endcase
  endfunction
endpackage

// File: rtl/instr_encoder.sv
// instr_encoder: combinational mapping of symbolic instruction fields to a 32-bit MIPS word
module instr_encoder
  import mips_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);
  mnem_t m;
  assign m = mnem_t'(op);
  assign illegal = m == M_ILLEGAL;
  assign word = illegal ? NOP
              : m == M_R ? {OP_R, rs, rt, rd, 5'd0, funct}
              : (m == M_J || m == M_JAL) ? {opcode(m), target}
              : {opcode(m), rs, rt, m == M_MOVE ? 16'd0 : imm};
endmodule

// File: rtl/program_loader.sv
// program_loader: streams encoded instructions into consecutive instruction-memory words from a base
module program_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0] rem;
  logic [31:0] word, enc_word;
  logic enc_illegal;
  instr_encoder u_enc (
    .op(in_op), .rs(in_rs), .rt(in_rt), .rd(in_rd), .funct(in_funct),
    .imm(in_imm), .target(in_target), .word(enc_word), .illegal(enc_illegal)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !start ? IDLE : word_count == '0 ? DONE : ACCEPT;
      ACCEPT:  nxt = in_valid ? WRITE : ACCEPT;
      WRITE:   nxt = rem == (ADDR_W+1)'(1) ? DONE : ACCEPT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      rem   <= '0;
      word  <= '0;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        ptr <= base_addr;
        rem <= word_count;
        err <= 1'b0;
      end
      if (state == ACCEPT && in_valid) begin
        word <= enc_word;
        err  <= err | enc_illegal;
      end
      if (state == WRITE) begin
        ptr <= ptr + 1'b1;
        rem <= rem - 1'b1;
      end
    end
  end
  // the write port shows the registered pointer and word; only the strobe depends on state
  assign in_ready  = state == ACCEPT;
  assign mem_we    = state == WRITE;
  assign mem_addr  = ptr;
  assign mem_wdata = word;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven encoding checks plus directed multi-cycle load sequences
module tb_program_loader;
  logic clk = 0, reset = 1, start = 0, in_valid = 0;
  logic [7:0] base_addr = 0;
  logic [8:0] word_count = 0;
  logic [3:0] in_op = 0;
  logic [4:0] in_rs = 0, in_rt = 0, in_rd = 0;
  logic [5:0] in_funct = 0;
  logic [15:0] in_imm = 0;
  logic [25:0] in_target = 0;
  logic in_ready, mem_we, busy, done, err;
  logic [7:0] mem_addr;
  logic [31:0] mem_wdata;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] wa[$];
  logic [31:0] wd[$];

  typedef struct {
    logic [3:0] op; logic [4:0] rs, rt, rd; logic [5:0] funct;
    logic [15:0] imm; logic [25:0] target; logic [31:0] exp; logic eerr;
  } vec_t;
  vec_t tbl[9];

  program_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) begin wa.push_back(mem_addr); wd.push_back(mem_wdata); end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_fields(input vec_t v);
    in_op = v.op; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
    in_funct = v.funct; in_imm = v.imm; in_target = v.target;
  endtask

  task automatic start_load(input logic [7:0] b, input logic [8:0] n);
    @(negedge clk); start = 1; base_addr = b; word_count = n;
    @(negedge clk); start = 0;
  endtask

  task automatic apply(input vec_t v);
    int k = 0;
    set_fields(v); in_valid = 1;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    if (!in_ready) chk("ready_timeout", 0, 1);
    @(negedge clk); in_valid = 0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 50) begin @(negedge clk); k++; end
    chk("done_seen", 32'(done), 1);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_outs"}, {in_ready, mem_we, busy, done, err}, 0);
    chk({nm, "_addr"}, 32'(mem_addr), 0);
    chk({nm, "_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{4'd1,  5'd1,  5'd2,  5'd31, 6'h3f, 16'h0005, 26'h3ffffff, 32'h08220005, 1'b0};
    tbl[1] = '{4'd0,  5'd1,  5'd2,  5'd3,  6'h20, 16'hffff, 26'h3ffffff, 32'h00221820, 1'b0};
    tbl[2] = '{4'd10, 5'd4,  5'd5,  5'd9,  6'h11, 16'hffff, 26'h0,       32'h8C85FFFF, 1'b0};
    tbl[3] = '{4'd12, 5'd7,  5'd8,  5'd9,  6'h2a, 16'habcd, 26'h10,      32'hE0000010, 1'b0};
    tbl[4] = '{4'd13, 5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h10,      32'hE4000010, 1'b0};
    tbl[5] = '{4'd14, 5'd3,  5'd4,  5'd5,  6'h15, 16'h1234, 26'h155,     32'h80640000, 1'b0};
    tbl[6] = '{4'd7,  5'd2,  5'd7,  5'd1,  6'h01, 16'h0004, 26'h0,       32'h40470004, 1'b0};
    tbl[7] = '{4'd15, 5'd31, 5'd31, 5'd31, 6'h3f, 16'hffff, 26'h3ffffff, 32'h00000000, 1'b1};
    tbl[8] = '{4'd5,  5'd31, 5'd0,  5'd6,  6'h22, 16'h8000, 26'h0,       32'h1FE08000, 1'b0};
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 0;

    for (int i = 0; i < 9; i++) begin
      wa.delete(); wd.delete();
      start_load(8'h10 + 8'(i), 9'd1);
      apply(tbl[i]);
      wait_done();
      chk($sformatf("v%0d_nwrites", i), wa.size(), 1);
      if (wa.size() == 1) begin
        chk($sformatf("v%0d_addr", i), 32'(wa[0]), 32'h10 + i);
        chk($sformatf("v%0d_data", i), wd[0], tbl[i].exp);
      end
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].eerr));
    end

    // two words, in_valid held high: in_ready alternates, done in cycle 2N+1 after start
    wa.delete(); wd.delete();
    start_load(8'h40, 9'd2);
    set_fields(tbl[1]); in_valid = 1;
    chk("two_rdy1", 32'(in_ready), 1);
    @(negedge clk); chk("two_rdy2", {in_ready, mem_we}, 2'b01); set_fields(tbl[2]);
    @(negedge clk); chk("two_rdy3", {in_ready, mem_we}, 2'b10);
    @(negedge clk); chk("two_rdy4", {in_ready, mem_we}, 2'b01);
    @(negedge clk); chk("two_done", {done, busy, in_ready}, 3'b110);
    in_valid = 0;
    @(negedge clk); chk("two_idle", {done, busy}, 0);
    chk("two_nwrites", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("two_a0", {wa[0], wd[0]}, {8'h40, 32'h00221820});
      chk("two_a1", {wa[1], wd[1]}, {8'h41, 32'h8C85FFFF});
    end

    // zero-length load
    wa.delete(); wd.delete();
    start_load(8'h20, 9'd0);
    chk("zero_done", {done, busy}, 2'b11);
    @(negedge clk); chk("zero_after", {done, busy}, 0);
    chk("zero_nwrites", wa.size(), 0);

    // start while busy is ignored
    wa.delete(); wd.delete();
    start_load(8'h50, 9'd1);
    start = 1; base_addr = 8'h99; word_count = 9'd5;
    @(negedge clk); start = 0;
    apply(tbl[0]);
    wait_done();
    @(negedge clk); chk("busy_start_idle", 32'(busy), 0);
    chk("busy_start_n", wa.size(), 1);
    if (wa.size() == 1) chk("busy_start_a", {wa[0], wd[0]}, {8'h50, 32'h08220005});

    // address wrap
    wa.delete(); wd.delete();
    start_load(8'hff, 9'd2);
    apply(tbl[3]); apply(tbl[4]);
    wait_done();
    chk("wrap_n", wa.size(), 2);
    if (wa.size() == 2) chk("wrap_addrs", {wa[0], wa[1]}, 16'hff00);

    // err sticky through done and idle, cleared by the next start
    start_load(8'h30, 9'd1);
    apply(tbl[7]);
    wait_done();
    chk("err_done", 32'(err), 1);
    @(negedge clk); @(negedge clk); chk("err_idle", {busy, err}, 2'b01);
    start_load(8'h31, 9'd1);
    chk("err_cleared", {busy, err}, 2'b10);
    apply(tbl[0]); wait_done();

    // reset during the second write of three
    wa.delete(); wd.delete();
    start_load(8'h60, 9'd3);
    apply(tbl[7]);
    apply(tbl[0]);
    chk("rst_in_write", {mem_we, err}, 2'b11);
    reset = 1;
    @(negedge clk); chk_reset_outputs("midrst");
    reset = 0;
    set_fields(tbl[1]); in_valid = 1;
    repeat (4) @(negedge clk);
    in_valid = 0;
    chk("midrst_nwrites", wa.size(), 2);
    chk("midrst_busy", 32'(busy), 0);

    // fresh load after abort
    wa.delete(); wd.delete();
    start_load(8'h70, 9'd1);
    apply(tbl[5]);
    wait_done();
    chk("fresh_n", wa.size(), 1);
    if (wa.size() == 1) chk("fresh_a", {wa[0], wd[0]}, {8'h70, 32'h80640000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/program_loader.md
# program_loader

Sequential writer that fills instruction memory for the single-cycle MIPS core. It accepts symbolic instructions over a valid/ready stream and encodes each into a 32-bit word using the opcodes the core's decoder recognises. It writes the words to consecutive instruction-memory addresses from a programmable base. It sits beside the instruction memory on the testbench/boot side and is inactive once the core runs.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width; the word count is ADDR_W+1 bits.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address, latched on start.
- word_count  in  ADDR_W+1  number of words to load, latched on start.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  block accepts fields this cycle.
- in_op  in  4  mnemonic: 0 R, 1 ADDI, 2 SUBI, 3 ANDI, 4 ORI, 5 SLTI, 6 LW, 7 SW, 8 LB, 9 SB, 10 BEQ, 11 BNE, 12 J, 13 JAL, 14 MOVE, 15 illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_funct  in  6  R-type function field.
- in_imm  in  16  I-type immediate.
- in_target  in  26  J-type target.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  encoded word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the load completes.
- err  out  1  sticky illegal-op flag; cleared on the next accepted start.

## Operation
- Opcodes [31:26]: R 000000, ADDI 000010, SUBI 000011, ANDI 000100, ORI 000101, SLTI 000111, LW 001000, SW 010000, LB 001001, SB 010001, BEQ 100011, BNE 100111, J 111000, JAL 111001, MOVE 100000.
- R format: op | rs | rt | rd | shamt=0 | funct.
- I format (ADDI through BNE): op | rs | rt | imm.
- MOVE format: op | rs | rt | imm=0. in_imm is ignored.
- J format (J, JAL): op | target.
- in_op=15 encodes 32'h0000_0000 (NOP), is still written, and sets err.
- FSM states:
  - IDLE: on start, latch ptr=base_addr, rem=word_count, and clear err. Go to DONE if word_count=0, otherwise ACCEPT.
  - ACCEPT: in_ready=1. On in_valid, register the encoded word and go to WRITE.
  - WRITE: mem_we=1, mem_addr=ptr, mem_wdata=word. Then ptr+1 (wraps mod 2^ADDR_W) and rem-1. Go to DONE if rem becomes 0, otherwise ACCEPT.
  - DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored. in_valid outside ACCEPT is ignored; in_ready is 0 there.
- Unused field inputs do not affect the word (e.g. in_imm for R, in_rd for I).

## Timing
- Reset values: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, ptr=0, rem=0.
- Reset mid-load aborts immediately. Words already written stay in memory; nothing further is written.
- All outputs are registered or pure functions of state. No combinational in→out path except in_ready, which is decoded from state.
- Handshake is accepted in cycle t when in_valid=1 in ACCEPT. mem_we is high in cycle t+1, and in_ready is high again in t+2.
- Throughput: 1 word per 2 cycles. N words from start take 2N+2 cycles until done, done inclusive.
- word_count=0: done asserts 2 cycles after start (IDLE→DONE); no write occurs.
- Address wrap: base=2^ADDR_W−1 with count 2 writes addresses 2^ADDR_W−1, then 0.

## Structure
- Shared package `mips_pkg`:
  - 6-bit opcode localparams (same values as the core decoder);
  - the 4-bit mnemonic enum;
  - the NOP constant.
- Natural sub-module `instr_encoder`: combinational mapping of fields to a 32-bit word plus an illegal flag. program_loader holds the FSM, pointer, remaining count and registers.

## Test plan
- start base=0x10, count=1; ADDI rs=1 rt=2 imm=5 -> single write addr 0x10 data 0x08220005, then done pulse, err=0.
- R rs=1 rt=2 rd=3 funct=0x20 then BEQ rs=4 rt=5 imm=0xFFFF, count=2 -> writes 0x00221820 @base, 0x8C85FFFF @base+1, with in_valid held high throughout (in_ready alternates).
- J target=0x10 and JAL target=0x10 -> 0xE0000010 and 0xE4000010; MOVE rs=3 rt=4 imm=0x1234 -> 0x80640000.
- in_op=15 -> data 0x00000000 written and err=1. err holds through done and clears on the next start.
- count=0 -> done 2 cycles after start and no mem_we. start pulsed while busy -> ignored.
- Assert reset during WRITE of word 2 of 3 -> next cycle IDLE, all outputs at reset values, no third write. A fresh load afterwards works.
